multicycle_ctrl: RTL and testbench

Multi-cycle main controller for the 19-bit CPU, replacing the single-cycle opcode decoder when the datapath shares one memory port and one ALU across cycles. A Moore FSM sequences fetch, decode, execute, memory and writeback steps per instruction and drives the datapath mux selects and write enables. A ready/request handshake stalls the FSM on slow memory. The opcode width and BNE support are parameters, and illegal opcodes trap.

---
 rtl/multicycle_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style main controller for the multi-cycle 19-bit CPU.
// Sequences fetch/decode/execute/memory/writeback over a shared memory port and
// ALU, stalls on mem_ready, and traps on illegal opcodes.
module multicycle_ctrl #(
   parameter int unsigned OPW        = 5,
   parameter bit          ENABLE_BNE = 1'b1
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [OPW-1:0] op,
   input  logic           zero,
   input  logic           mem_ready,
   output logic           mem_req,
   output logic           adrsrc,
   output logic           irwrite,
   output logic           pcwrite,
   output logic           memwrite,
   output logic           regwrite,
   output logic [1:0]     resultsrc,
   output logic [1:0]     alusrca,
   output logic [1:0]     alusrcb,
   output logic [1:0]     aluop,
   output logic [1:0]     immsrc,
   output logic           instr_done,
   output logic           illegal,
   output logic [3:0]     state_o
);

   typedef enum logic [3:0] {
      S_RST      = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMREAD  = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWRITE = 4'd6,
      S_EXECR    = 4'd7,
      S_EXECI    = 4'd8,
      S_ALUWB    = 4'd9,
      S_BEQ      = 4'd10,
      S_BNE      = 4'd11,
      S_JAL      = 4'd12,
      S_TRAP     = 4'd15
   } state_t;

   localparam logic [4:0] OP_R   = 5'b00001;
   localparam logic [4:0] OP_LW  = 5'b00011;
   localparam logic [4:0] OP_SW  = 5'b00100;
   localparam logic [4:0] OP_BEQ = 5'b01000;
   localparam logic [4:0] OP_BNE = 5'b01110;
   localparam logic [4:0] OP_JAL = 5'b10000;

   state_t     state;
   state_t     nxt;

   logic [4:0] lo;
   logic       upper_ok;
   logic       is_r, is_i, is_lw, is_sw, is_beq, is_bne, is_jal;

   // Registered per-state flags used to gate the ready/zero-dependent enables
   logic       fetch_q;
   logic       beq_q;
   logic       bne_q;
   logic       jal_q;
   logic       mwr_q;
   logic       done_q;
   logic       imm_en;

   assign lo       = op[4:0];
   assign upper_ok = ((op >> 5) == '0);

   // Opcode class decode; any nonzero bit above [4:0] makes the opcode illegal
   always_comb begin
      is_r   = upper_ok && (lo == OP_R);
      is_i   = upper_ok && (lo inside {5'b00010, 5'b00101, 5'b00110, 5'b00111,
                                       5'b01001, 5'b01010, 5'b01011});
      is_lw  = upper_ok && (lo == OP_LW);
      is_sw  = upper_ok && (lo == OP_SW);
      is_beq = upper_ok && (lo == OP_BEQ);
      is_bne = upper_ok && (lo == OP_BNE) && ENABLE_BNE;
      is_jal = upper_ok && (lo == OP_JAL);
   end

   // Immediate format select, combinational from op; forced to 0 in RST and TRAP
   always_comb begin
      immsrc = '0;
      if (imm_en) begin
         if (is_sw)                immsrc = 2'b01;
         else if (is_beq || is_bne) immsrc = 2'b10;
         else if (is_jal)          immsrc = 2'b11;
      end
   end

   // Next-state logic
   always_comb begin
      nxt = state;
      case (state)
         S_RST:      nxt = S_FETCH;
         S_FETCH:    if (mem_ready) nxt = S_DECODE;
         S_DECODE: begin
            if (is_lw || is_sw) nxt = S_MEMADR;
            else if (is_r)      nxt = S_EXECR;
            else if (is_i)      nxt = S_EXECI;
            else if (is_beq)    nxt = S_BEQ;
            else if (is_bne)    nxt = S_BNE;
            else if (is_jal)    nxt = S_JAL;
            else                nxt = S_TRAP;
         end
         S_MEMADR:   nxt = is_sw ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (mem_ready) nxt = S_MEMWB;
         S_MEMWRITE: if (mem_ready) nxt = S_FETCH;
         S_EXECR, S_EXECI, S_JAL:          nxt = S_ALUWB;
         S_MEMWB, S_ALUWB, S_BEQ, S_BNE:   nxt = S_FETCH;
         S_TRAP:     nxt = S_TRAP;
         default:    nxt = S_TRAP;
      endcase
   end

   // State register with outputs decoded from the next state, so every
   // state-only output comes straight from a flop and clears asynchronously
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_RST;
         mem_req   <= 1'b0;
         adrsrc    <= 1'b0;
         memwrite  <= 1'b0;
         regwrite  <= 1'b0;
         resultsrc <= '0;
         alusrca   <= '0;
         alusrcb   <= '0;
         aluop     <= '0;
         illegal   <= 1'b0;
         fetch_q   <= 1'b0;
         beq_q     <= 1'b0;
         bne_q     <= 1'b0;
         jal_q     <= 1'b0;
         mwr_q     <= 1'b0;
         done_q    <= 1'b0;
         imm_en    <= 1'b0;
      end else begin
         state     <= nxt;
         mem_req   <= 1'b0;
         adrsrc    <= 1'b0;
         memwrite  <= 1'b0;
         regwrite  <= 1'b0;
         resultsrc <= '0;
         alusrca   <= '0;
         alusrcb   <= '0;
         aluop     <= '0;
         illegal   <= 1'b0;
         fetch_q   <= 1'b0;
         beq_q     <= 1'b0;
         bne_q     <= 1'b0;
         jal_q     <= 1'b0;
         mwr_q     <= 1'b0;
         done_q    <= 1'b0;
         imm_en    <= 1'b1;
         case (nxt)
            S_RST: imm_en <= 1'b0;
            S_FETCH: begin
               mem_req   <= 1'b1;
               alusrcb   <= 2'b10;
               resultsrc <= 2'b10;
               fetch_q   <= 1'b1;
            end
            S_DECODE: begin
               alusrca <= 2'b01;
               alusrcb <= 2'b01;
            end
            S_MEMADR: begin
               alusrca <= 2'b10;
               alusrcb <= 2'b01;
            end
            S_MEMREAD: begin
               mem_req <= 1'b1;
               adrsrc  <= 1'b1;
            end
            S_MEMWB: begin
               resultsrc <= 2'b01;
               regwrite  <= 1'b1;
               done_q    <= 1'b1;
            end
            S_MEMWRITE: begin
               mem_req  <= 1'b1;
               adrsrc   <= 1'b1;
               memwrite <= 1'b1;
               mwr_q    <= 1'b1;
            end
            S_EXECR: begin
               alusrca <= 2'b10;
               aluop   <= 2'b10;
            end
            S_EXECI: begin
               alusrca <= 2'b10;
               alusrcb <= 2'b01;
               aluop   <= 2'b10;
            end
            S_ALUWB: begin
               regwrite <= 1'b1;
               done_q   <= 1'b1;
            end
            S_BEQ: begin
               alusrca <= 2'b10;
               aluop   <= 2'b01;
               beq_q   <= 1'b1;
               done_q  <= 1'b1;
            end
            S_BNE: begin
               alusrca <= 2'b10;
               aluop   <= 2'b01;
               bne_q   <= 1'b1;
               done_q  <= 1'b1;
            end
            S_JAL: begin
               alusrca <= 2'b01;
               alusrcb <= 2'b10;
               jal_q   <= 1'b1;
            end
            S_TRAP: begin
               illegal <= 1'b1;
               imm_en  <= 1'b0;
            end
            default: imm_en <= 1'b0;
         endcase
      end
   end

   // Enables qualified by the memory handshake or the ALU zero flag
   assign irwrite    = fetch_q & mem_ready;
   assign pcwrite    = (fetch_q & mem_ready) | (beq_q & zero) | (bne_q & ~zero) | jal_q;
   assign instr_done = done_q | (mwr_q & mem_ready);
   assign state_o    = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl. Expected per-cycle
// output words are queued when an instruction is issued and compared as the
// DUT steps through it.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset_n, reset_nb;
   logic [5:0] op;
   logic [4:0] op_nb;
   logic       zero, mem_ready;

   logic       m_mem_req, m_adrsrc, m_irwrite, m_pcwrite, m_memwrite, m_regwrite;
   logic [1:0] m_resultsrc, m_alusrca, m_alusrcb, m_aluop, m_immsrc;
   logic       m_instr_done, m_illegal;
   logic [3:0] m_state;

   logic       n_mem_req, n_adrsrc, n_irwrite, n_pcwrite, n_memwrite, n_regwrite;
   logic [1:0] n_resultsrc, n_alusrca, n_alusrcb, n_aluop, n_immsrc;
   logic       n_instr_done, n_illegal;
   logic [3:0] n_state;

   logic [21:0] w_m, w_n;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   logic [21:0] eq[$];
   bit          rq[$];
   string       tq[$];

   always #5 clk = ~clk;

   assign op_nb = op[4:0];
   assign w_m = {m_state, m_illegal, m_instr_done, m_immsrc, m_aluop, m_alusrcb, m_alusrca,
                 m_resultsrc, m_regwrite, m_memwrite, m_pcwrite, m_irwrite, m_adrsrc, m_mem_req};
   assign w_n = {n_state, n_illegal, n_instr_done, n_immsrc, n_aluop, n_alusrcb, n_alusrca,
                 n_resultsrc, n_regwrite, n_memwrite, n_pcwrite, n_irwrite, n_adrsrc, n_mem_req};

   multicycle_ctrl #(.OPW(6), .ENABLE_BNE(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
      .mem_req(m_mem_req), .adrsrc(m_adrsrc), .irwrite(m_irwrite), .pcwrite(m_pcwrite),
      .memwrite(m_memwrite), .regwrite(m_regwrite), .resultsrc(m_resultsrc),
      .alusrca(m_alusrca), .alusrcb(m_alusrcb), .aluop(m_aluop), .immsrc(m_immsrc),
      .instr_done(m_instr_done), .illegal(m_illegal), .state_o(m_state)
   );

   multicycle_ctrl #(.OPW(5), .ENABLE_BNE(1'b0)) dut_nb (
      .clk(clk), .reset_n(reset_nb), .op(op_nb), .zero(zero), .mem_ready(mem_ready),
      .mem_req(n_mem_req), .adrsrc(n_adrsrc), .irwrite(n_irwrite), .pcwrite(n_pcwrite),
      .memwrite(n_memwrite), .regwrite(n_regwrite), .resultsrc(n_resultsrc),
      .alusrca(n_alusrca), .alusrcb(n_alusrcb), .aluop(n_aluop), .immsrc(n_immsrc),
      .instr_done(n_instr_done), .illegal(n_illegal), .state_o(n_state)
   );

   task automatic chk(input string tag, input logic [21:0] got, input logic [21:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   function automatic logic [1:0] imm_of(input logic [5:0] o, input bit en_bne);
      case (o)
         6'b000010, 6'b000101, 6'b000110, 6'b000111,
         6'b001001, 6'b001010, 6'b001011, 6'b000011: return 2'b00;
         6'b000100: return 2'b01;
         6'b001000: return 2'b10;
         6'b001110: return en_bne ? 2'b10 : 2'b00;
         6'b010000: return 2'b11;
         default:   return 2'b00;
      endcase
   endfunction

   function automatic logic [21:0] exp_word(input logic [3:0] st, input logic [5:0] o,
                                            input bit en_bne, input bit rdy, input bit z);
      logic       mr, ad, irw, pcw, mw, rw, dn, il;
      logic [1:0] rs, aa, ab, ao, im;
      {mr, ad, irw, pcw, mw, rw, dn, il} = '0;
      {rs, aa, ab, ao} = '0;
      case (st)
         4'd1:  begin mr = 1; irw = rdy; pcw = rdy; ab = 2'b10; rs = 2'b10; end
         4'd2:  begin aa = 2'b01; ab = 2'b01; end
         4'd3:  begin aa = 2'b10; ab = 2'b01; end
         4'd4:  begin mr = 1; ad = 1; end
         4'd5:  begin rs = 2'b01; rw = 1; dn = 1; end
         4'd6:  begin mr = 1; ad = 1; mw = 1; dn = rdy; end
         4'd7:  begin aa = 2'b10; ao = 2'b10; end
         4'd8:  begin aa = 2'b10; ab = 2'b01; ao = 2'b10; end
         4'd9:  begin rw = 1; dn = 1; end
         4'd10: begin aa = 2'b10; ao = 2'b01; pcw = z; dn = 1; end
         4'd11: begin aa = 2'b10; ao = 2'b01; pcw = ~z; dn = 1; end
         4'd12: begin aa = 2'b01; ab = 2'b10; pcw = 1; end
         4'd15: il = 1;
         default: ;
      endcase
      im = (st != 4'd0 && st != 4'd15) ? imm_of(o, en_bne) : 2'b00;
      return {st, il, dn, im, ao, ab, aa, rs, rw, mw, pcw, irw, ad, mr};
   endfunction

   task automatic push(input string tag, input logic [3:0] st, input bit rdy, input bit sel);
      eq.push_back(exp_word(st, op, !sel, rdy, zero));
      rq.push_back(rdy);
      tq.push_back(tag);
   endtask

   // Each queued cycle: drive mem_ready after the edge, compare on the falling edge
   task automatic drain(input bit sel);
      while (rq.size() > 0) begin
         @(posedge clk);
         #1 mem_ready = rq.pop_front();
         @(negedge clk);
         chk(tq.pop_front(), sel ? w_n : w_m, eq.pop_front());
      end
   endtask

   // Queue the expected state walk of one instruction, then run it
   task automatic instr(input string tag, input logic [5:0] o, input bit z,
                        input int unsigned fstall, input int unsigned mstall, input bit sel);
      bit en;
      en = !sel;
      op = o;
      zero = z;
      for (int unsigned i = 0; i < fstall; i++) push(tag, 4'd1, 1'b0, sel);
      push(tag, 4'd1, 1'b1, sel);
      push(tag, 4'd2, 1'($urandom_range(0, 1)), sel);
      case (o)
         6'b000011: begin
            push(tag, 4'd3, 1'($urandom_range(0, 1)), sel);
            for (int unsigned i = 0; i < mstall; i++) push(tag, 4'd4, 1'b0, sel);
            push(tag, 4'd4, 1'b1, sel);
            push(tag, 4'd5, 1'($urandom_range(0, 1)), sel);
         end
         6'b000100: begin
            push(tag, 4'd3, 1'($urandom_range(0, 1)), sel);
            for (int unsigned i = 0; i < mstall; i++) push(tag, 4'd6, 1'b0, sel);
            push(tag, 4'd6, 1'b1, sel);
         end
         6'b000001: begin
            push(tag, 4'd7, 1'($urandom_range(0, 1)), sel);
            push(tag, 4'd9, 1'($urandom_range(0, 1)), sel);
         end
         6'b000010, 6'b000101, 6'b000110, 6'b000111,
         6'b001001, 6'b001010, 6'b001011: begin
            push(tag, 4'd8, 1'($urandom_range(0, 1)), sel);
            push(tag, 4'd9, 1'($urandom_range(0, 1)), sel);
         end
         6'b001000: push(tag, 4'd10, 1'($urandom_range(0, 1)), sel);
         6'b010000: begin
            push(tag, 4'd12, 1'($urandom_range(0, 1)), sel);
            push(tag, 4'd9, 1'($urandom_range(0, 1)), sel);
         end
         default: begin
            if (o == 6'b001110 && en) push(tag, 4'd11, 1'($urandom_range(0, 1)), sel);
            else for (int i = 0; i < 3; i++) push(tag, 4'd15, 1'($urandom_range(0, 1)), sel);
         end
      endcase
      drain(sel);
   endtask

   // Asynchronous reset pulse between clock edges; outputs must clear at once
   task automatic do_reset(input string tag, input bit sel);
      #2;
      if (sel) reset_nb = 1'b0;
      else     reset_n  = 1'b0;
      #1 chk(tag, sel ? w_n : w_m, 22'h0);
      @(negedge clk);
      if (sel) reset_nb = 1'b1;
      else     reset_n  = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0; reset_nb = 1'b0;
      op = '0; zero = 1'b0; mem_ready = 1'b0;
      #1 chk("reset_m", w_m, 22'h0);
      chk("reset_nb", w_n, 22'h0);
      repeat (2) @(negedge clk);
      chk("reset_hold", w_m, 22'h0);
      reset_n = 1'b1;

      instr("lw",       6'b000011, 1'b0, 0, 0, 1'b0);
      instr("r_stall",  6'b000001, 1'b0, 3, 0, 1'b0);
      instr("beq_z1",   6'b001000, 1'b1, 0, 0, 1'b0);
      instr("beq_z0",   6'b001000, 1'b0, 0, 0, 1'b0);
      instr("bne_z0",   6'b001110, 1'b0, 0, 0, 1'b0);
      instr("bne_z1",   6'b001110, 1'b1, 0, 0, 1'b0);
      instr("sw_stall", 6'b000100, 1'b0, 0, 2, 1'b0);
      instr("itype",    6'b000101, 1'b1, 0, 0, 1'b0);
      instr("itype_b",  6'b001011, 1'b0, 1, 0, 1'b0);
      instr("jal",      6'b010000, 1'b0, 0, 0, 1'b0);
      instr("lw_stall", 6'b000011, 1'b1, 2, 1, 1'b0);

      // Abort an LW while stalled in MEMREAD
      op = 6'b000011;
      zero = 1'b0;
      push("lw_abort", 4'd1, 1'b1, 1'b0);
      push("lw_abort", 4'd2, 1'b1, 1'b0);
      push("lw_abort", 4'd3, 1'b0, 1'b0);
      push("lw_abort", 4'd4, 1'b0, 1'b0);
      drain(1'b0);
      do_reset("rst_mid", 1'b0);
      instr("post_rst", 6'b000001, 1'b0, 0, 0, 1'b0);

      instr("ill_op",   6'b011111, 1'b0, 0, 0, 1'b0);
      do_reset("rst_trap", 1'b0);
      instr("ill_upper", 6'b100001, 1'b0, 0, 0, 1'b0);
      do_reset("rst_trap2", 1'b0);
      instr("after_trap", 6'b000100, 1'b0, 0, 0, 1'b0);

      // BNE disabled instance: BNE traps and stays trapped until reset
      reset_n  = 1'b0;
      reset_nb = 1'b1;
      instr("nb_beq", 6'b001000, 1'b1, 0, 0, 1'b1);
      instr("nb_bne", 6'b001110, 1'b0, 0, 0, 1'b1);
      do_reset("nb_rst", 1'b1);
      instr("nb_lw",  6'b000011, 1'b0, 0, 0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
